pipelined_tree_adder: RTL and testbench
=======================================

Name: pipelined_tree_adder

Overview:
- Parametrised, pipelined successor to the combinational power-of-2 tree adder.
- Reduces INPUTS_AMOUNT operands (any count ≥1) of width P to a single sum.
- Configurable register insertion between adder layers, a valid/ready handshake with backpressure, and a per-beat signed/unsigned mode.
- Optional per-beat accumulation across a `last`-terminated sequence of beats.
- Sits between the MAC array column outputs and the result writeback path.

Parameters:
- INPUTS_AMOUNT, 8, operand count; any value ≥1. Internally zero-padded to the next power of 2.
- P, 8, operand width in bits.
- PIPE_STRIDE, 1, number of adder layers between pipeline registers. 0 = combinational tree.
- ACC_EXTRA, 8, extra accumulator headroom bits.
- Derived L = $clog2(INPUTS_AMOUNT), which is 0 when INPUTS_AMOUNT = 1.
- Derived S = (PIPE_STRIDE == 0) ? 0 : ceil(L/PIPE_STRIDE).
- Derived OUT_W = P + L + ACC_EXTRA.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- in_data_i, in, P x INPUTS_AMOUNT (unpacked array), operands.
- in_signed_i, in, 1, beat is two's-complement when 1.
- in_accumulate_i, in, 1, beat is added into the accumulator.
- in_last_i, in, 1, closes an accumulation sequence; only meaningful when in_accumulate_i = 1.
- in_valid_i, in, 1, input beat valid.
- in_ready_o, out, 1, input beat accepted when in_valid_i && in_ready_o.
- out_data_o, out, OUT_W, result.
- out_valid_o, out, 1, result valid.
- out_ready_i, in, 1, downstream accepts result.

Behaviour:
- Reset:
  - All stage valids, out_valid_o, the accumulator and out_data_o reset to 0.
  - Deasserting rst_ni mid-operation discards in-flight beats and any partial accumulation.
- Tree arithmetic:
  - Layer k adds pairs of (P+k)-bit values into (P+k+1)-bit results.
  - Each operand is extended by one bit: sign extension if the beat's signed flag is 1, zero extension otherwise.
  - Padding operands are 0.
  - With INPUTS_AMOUNT = 1 the sum is the operand itself.
- Sideband: in_signed_i, in_accumulate_i and in_last_i are captured with the beat and travel with it through every stage. Mode changes per beat with no bubbles.
- Pipeline:
  - S tree register stages, then one output/accumulator stage.
  - Latency from input handshake to out_valid_o is S+1 cycles. Example: INPUTS_AMOUNT=5, PIPE_STRIDE=1 gives L=3, S=3, latency 4.
  - Throughput is 1 beat/cycle while out_ready_i is high.
- Handshake:
  - A stage loads when it is empty or its content advances in the same cycle.
  - in_ready_o = !stage1_valid || stage1_advances. This is a combinational ready chain from the output; no skid buffer.
  - While out_valid_o && !out_ready_i, out_data_o and out_valid_o are held stable and the final tree stage does not advance.
  - in_valid_i may be held without in_ready_o; no beat is lost or duplicated, and order is preserved.
- Output stage: let sum be the tree result extended to OUT_W (sign extension if the beat is signed, else zero extension). On advance:
  - accumulate = 0: out_data_o <= sum, out_valid_o <= 1. The accumulator is untouched.
  - accumulate = 1, last = 0: acc <= acc + sum. No output is produced; the beat is consumed even if out_ready_i is low, provided the output register is not stalled.
  - accumulate = 1, last = 1: out_data_o <= acc + sum, out_valid_o <= 1, acc <= 0.
  - If no result is loaded and out_ready_i = 1, out_valid_o <= 0.
- Overflow: the accumulator and output wrap modulo 2^OUT_W. No saturation and no flag.
- Simultaneous events: a beat arriving in the same cycle as output acceptance is loaded. There is no bubble when out_ready_i = 1 continuously.
- PIPE_STRIDE ≥ L gives S = 1. PIPE_STRIDE = 0 gives latency 1 (output register only).

Test Plan:
- Unsigned latency: INPUTS_AMOUNT=5, P=8, PIPE_STRIDE=1, ACC_EXTRA=8. Drive in_data_i={1,2,3,4,5}, unsigned, single beat → out_valid_o exactly 4 cycles after the handshake, out_data_o=15 (OUT_W=19).
- Signed vs unsigned: same config, five operands 0xFF. Signed beat → 0x7FFFB (-5). Next beat unsigned → 0x004FB (1275). Both results are back to back in consecutive cycles.
- Accumulation: three beats of five operands each = 1, accumulate=1, last on the third → exactly one out_valid_o pulse with out_data_o=15. Accumulator is 0 afterwards. A following non-accumulate beat of all 2 → 10.
- Backpressure: continuous input beats with values n=0..19 (all operands = n). Hold out_ready_i low for 10 cycles → in_ready_o falls once S+1=4 beats are buffered. out_data_o is stable while stalled. After release, results 5n are observed in order with none missing.
- Wrap: INPUTS_AMOUNT=2, P=4, ACC_EXTRA=1 (OUT_W=6). Accumulate 5 beats of {15,15}, last on the 5th → 150 mod 64 = 22.
- Reset mid-flight: assert rst_ni low with 3 beats in the pipeline and a partial accumulation → out_valid_o=0 immediately. After release, a fresh accumulate/last beat of sum 7 → out_data_o=7 (no stale accumulator contribution).

Source files
------------

// File: rtl/pipelined_tree_adder.sv
// pipelined_tree_adder
//   Reduces INPUTS_AMOUNT operands of P bits to a single sum through a binary
//   adder tree. The operand set is zero-padded up to the next power of two.
//   A pipeline register follows every PIPE_STRIDE adder layers, and one
//   follows the last layer. Behind the tree sits one output/accumulator
//   register. Every register stage uses a valid/ready handshake, and ready
//   propagates combinationally from the output back to the input. Each beat
//   carries its own signed/accumulate/last flags through the pipeline.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   in_data_i         operands, P bits x INPUTS_AMOUNT
//   in_signed_i       beat holds two's-complement operands
//   in_accumulate_i   beat is added into the accumulator
//   in_last_i         closes an accumulation sequence and emits acc + sum
//   in_valid_i        input beat valid
//   in_ready_o        input beat accepted when in_valid_i && in_ready_o
//   out_data_o        result, OUT_W = P + L + ACC_EXTRA bits, wraps modulo 2^OUT_W
//   out_valid_o       result valid
//   out_ready_i       downstream accepts result
module pipelined_tree_adder #(
    parameter int unsigned INPUTS_AMOUNT = 8,
    parameter int unsigned P             = 8,
    parameter int unsigned PIPE_STRIDE   = 1,
    parameter int unsigned ACC_EXTRA     = 8,
    localparam int unsigned L     = (INPUTS_AMOUNT > 1) ? $clog2(INPUTS_AMOUNT) : 0,
    localparam int unsigned OUT_W = P + L + ACC_EXTRA
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [P-1:0]     in_data_i [INPUTS_AMOUNT],
    input  logic             in_signed_i,
    input  logic             in_accumulate_i,
    input  logic             in_last_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int unsigned N          = 1 << L;
    localparam int unsigned TW         = P + L;
    localparam int unsigned STRIDE_DIV = (PIPE_STRIDE == 0) ? 1 : PIPE_STRIDE;

    logic out_en;

    // g_lvl[k] presents the layer-k node values, each P+k bits wide.
    // Layer 0 holds the raw operands. Every later layer either registers
    // its sums or passes them straight through.
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int unsigned NK = N >> k;
        logic [P+k-1:0] node [NK];
        logic           vld, sgn, acc, lst;

        if (k == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_op
                if (i < INPUTS_AMOUNT) begin : g_real
                    assign node[i] = in_data_i[i];
                end else begin : g_pad
                    assign node[i] = '0;
                end
            end
            assign vld = in_valid_i;
            assign sgn = in_signed_i;
            assign acc = in_accumulate_i;
            assign lst = in_last_i;
        end else begin : g_add
            localparam bit REG = (PIPE_STRIDE != 0) && (((k % STRIDE_DIV) == 0) || (k == L));
            logic [P+k-1:0] sum [NK];
            logic           up_rdy;
            logic           dn_rdy;

            // Widen each input by one bit (sign or zero per the beat flag)
            // so that the pair sum cannot overflow.
            for (genvar i = 0; i < NK; i++) begin : g_pair
                logic [P+k-2:0] a, b;
                assign a      = g_lvl[k-1].node[2*i];
                assign b      = g_lvl[k-1].node[2*i+1];
                assign sum[i] = {g_lvl[k-1].sgn & a[P+k-2], a}
                              + {g_lvl[k-1].sgn & b[P+k-2], b};
            end

            if (k == L) begin : g_tail
                assign dn_rdy = out_en;
            end else begin : g_mid
                assign dn_rdy = g_lvl[k+1].g_add.up_rdy;
            end

            if (REG) begin : g_reg
                logic [P+k-1:0] node_q [NK];
                logic [P+k-1:0] node_d [NK];
                logic           vld_q, vld_d, sgn_q, sgn_d, acc_q, acc_d, lst_q, lst_d;

                // The stage loads when it is empty or its content moves on.
                assign up_rdy = !vld_q || dn_rdy;

                always_comb begin
                    node_d = node_q;
                    vld_d  = vld_q;
                    sgn_d  = sgn_q;
                    acc_d  = acc_q;
                    lst_d  = lst_q;
                    if (up_rdy) begin
                        node_d = sum;
                        vld_d  = g_lvl[k-1].vld;
                        sgn_d  = g_lvl[k-1].sgn;
                        acc_d  = g_lvl[k-1].acc;
                        lst_d  = g_lvl[k-1].lst;
                    end
                end

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        node_q <= '{default: '0};
                        vld_q  <= 1'b0;
                        sgn_q  <= 1'b0;
                        acc_q  <= 1'b0;
                        lst_q  <= 1'b0;
                    end else begin
                        node_q <= node_d;
                        vld_q  <= vld_d;
                        sgn_q  <= sgn_d;
                        acc_q  <= acc_d;
                        lst_q  <= lst_d;
                    end
                end

                assign node = node_q;
                assign vld  = vld_q;
                assign sgn  = sgn_q;
                assign acc  = acc_q;
                assign lst  = lst_q;
            end else begin : g_comb
                assign up_rdy = dn_rdy;
                assign node   = sum;
                assign vld    = g_lvl[k-1].vld;
                assign sgn    = g_lvl[k-1].sgn;
                assign acc    = g_lvl[k-1].acc;
                assign lst    = g_lvl[k-1].lst;
            end
        end
    end

    if (L == 0) begin : g_rdy_direct
        assign in_ready_o = out_en;
    end else begin : g_rdy_tree
        assign in_ready_o = g_lvl[1].g_add.up_rdy;
    end

    logic [TW-1:0]    fin_node;
    logic             fin_vld, fin_sgn, fin_acc, fin_lst;
    logic [OUT_W-1:0] sum_ext;
    logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    assign fin_node = g_lvl[L].node[0];
    assign fin_vld  = g_lvl[L].vld;
    assign fin_sgn  = g_lvl[L].sgn;
    assign fin_acc  = g_lvl[L].acc;
    assign fin_lst  = g_lvl[L].lst;

    // A stalled output register also blocks accumulate-only beats.
    assign out_en = !out_valid_q || out_ready_i;

    always_comb begin
        sum_ext = OUT_W'(fin_node);
        for (int unsigned b = TW; b < OUT_W; b++) begin
            sum_ext[b] = fin_sgn & fin_node[TW-1];
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        if (out_en) begin
            out_valid_d = 1'b0;
            if (fin_vld) begin
                if (!fin_acc) begin
                    out_data_d  = sum_ext;
                    out_valid_d = 1'b1;
                end else if (!fin_lst) begin
                    acc_d = acc_q + sum_ext;
                end else begin
                    out_data_d  = acc_q + sum_ext;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_pipelined_tree_adder.sv
// tb_pipelined_tree_adder
//   Drives two instances of pipelined_tree_adder:
//     A: 5 x 8-bit operands, register after every layer (latency 4, 19-bit result)
//     B: 2 x 4-bit operands, combinational tree (latency 1, 6-bit result)
//   Every accepted beat updates an arithmetic reference model. The model
//   queues expected results, and a monitor per instance pops and compares
//   each result that the instance hands over.
module tb_pipelined_tree_adder;
    localparam int unsigned A_N = 5, A_P = 8, A_W = 19, A_S = 3;
    localparam int unsigned B_N = 2, B_P = 4, B_W = 6,  B_S = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [A_P-1:0] a_data [A_N];
    logic           a_sgn, a_acc, a_lst, a_valid, a_ready, a_out_valid, a_out_ready;
    logic [A_W-1:0] a_out;
    logic [B_P-1:0] b_data [B_N];
    logic           b_sgn, b_acc, b_lst, b_valid, b_ready, b_out_valid, b_out_ready;
    logic [B_W-1:0] b_out;

    pipelined_tree_adder #(.INPUTS_AMOUNT(A_N), .P(A_P), .PIPE_STRIDE(1), .ACC_EXTRA(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(a_data), .in_signed_i(a_sgn),
        .in_accumulate_i(a_acc), .in_last_i(a_lst), .in_valid_i(a_valid), .in_ready_o(a_ready),
        .out_data_o(a_out), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready));

    pipelined_tree_adder #(.INPUTS_AMOUNT(B_N), .P(B_P), .PIPE_STRIDE(0), .ACC_EXTRA(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(b_data), .in_signed_i(b_sgn),
        .in_accumulate_i(b_acc), .in_last_i(b_lst), .in_valid_i(b_valid), .in_ready_o(b_ready),
        .out_data_o(b_out), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready));

    int     n_checks = 0;
    int     n_fail   = 0;
    longint a_exp [$];
    longint b_exp [$];
    longint a_accm = 0, b_accm = 0;
    int     a_hs = 0, a_outs = 0, b_outs = 0;
    bit     a_rand_rdy = 0, b_rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual timeout/none required event", name);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input bit is_b, input longint sum, input bit ac, input bit l);
        longint mask;
        mask = is_b ? ((longint'(1) << B_W) - 1) : ((longint'(1) << A_W) - 1);
        if (is_b) begin
            if (!ac)     b_exp.push_back(sum & mask);
            else if (!l) b_accm += sum;
            else begin
                b_exp.push_back((b_accm + sum) & mask);
                b_accm = 0;
            end
        end else begin
            a_hs++;
            if (!ac)     a_exp.push_back(sum & mask);
            else if (!l) a_accm += sum;
            else begin
                a_exp.push_back((a_accm + sum) & mask);
                a_accm = 0;
            end
        end
    endfunction

    // Called at posedge+1. Returns at posedge+1 just after the accepting
    // edge, with valid still high so that beats can follow back to back.
    task automatic beat(input bit is_b, input int unsigned ops [5], input bit s, input bit ac, input bit l);
        longint      sum;
        int unsigned n;
        int unsigned p;
        bit          rdy;
        sum = 0;
        n   = is_b ? B_N : A_N;
        p   = is_b ? B_P : A_P;
        for (int unsigned i = 0; i < n; i++) begin
            longint v;
            v = longint'(ops[i]) & ((longint'(1) << p) - 1);
            if (s && v[p-1]) v -= (longint'(1) << p);
            sum += v;
            if (is_b) b_data[i] = ops[i][B_P-1:0];
            else      a_data[i] = ops[i][A_P-1:0];
        end
        if (is_b) begin
            b_sgn = s; b_acc = ac; b_lst = l; b_valid = 1'b1;
        end else begin
            a_sgn = s; a_acc = ac; a_lst = l; a_valid = 1'b1;
        end
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            rdy = is_b ? b_ready : a_ready;
            if (rdy) begin
                model(is_b, sum, ac, l);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        fail_now(is_b ? "b_handshake" : "a_handshake");
    endtask

    task automatic drain(input bit is_b);
        int sz;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            sz = is_b ? b_exp.size() : a_exp.size();
            if (sz == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        fail_now(is_b ? "b_drain" : "a_drain");
        @(posedge clk); #1;
    endtask

    task automatic latency(input bit is_b, input string name, input int unsigned req);
        int unsigned lat;
        lat = 0;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (is_b ? b_out_valid : a_out_valid) begin
                lat = c;
                break;
            end
        end
        check(name, lat, req);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitors. They also require a held result to stay put.
    logic [A_W-1:0] a_prev;
    logic [B_W-1:0] b_prev;
    bit             a_stalled = 0, b_stalled = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_stalled = 0;
            b_stalled = 0;
        end else begin
            if (a_stalled) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out, a_prev);
            end
            if (a_out_valid && a_out_ready) begin
                a_outs++;
                if (a_exp.size() == 0) fail_now("a_unexpected_result");
                else check("a_result", a_out, a_exp.pop_front());
            end
            a_stalled = a_out_valid && !a_out_ready;
            a_prev    = a_out;

            if (b_stalled) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_data", b_out, b_prev);
            end
            if (b_out_valid && b_out_ready) begin
                b_outs++;
                if (b_exp.size() == 0) fail_now("b_unexpected_result");
                else check("b_result", b_out, b_exp.pop_front());
            end
            b_stalled = b_out_valid && !b_out_ready;
            b_prev    = b_out;
        end
    end

    always @(posedge clk) begin
        #1;
        if (a_rand_rdy) a_out_ready = ($urandom_range(0, 3) != 0);
        if (b_rand_rdy) b_out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned ops [5];
        int          h0, o0;

        rst_n = 1'b0;
        a_valid = 0; a_sgn = 0; a_acc = 0; a_lst = 0; a_out_ready = 1;
        b_valid = 0; b_sgn = 0; b_acc = 0; b_lst = 0; b_out_ready = 1;
        for (int unsigned i = 0; i < A_N; i++) a_data[i] = '0;
        for (int unsigned i = 0; i < B_N; i++) b_data[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("a_reset_valid", a_out_valid, 0);
        check("a_reset_data", a_out, 0);
        check("a_reset_ready", a_ready, 1);
        check("b_reset_valid", b_out_valid, 0);
        check("b_reset_data", b_out, 0);
        @(posedge clk); #1;

        // Unsigned single beat: 15 after S+1 cycles.
        beat(0, '{1, 2, 3, 4, 5}, 0, 0, 0);
        a_valid = 0;
        latency(0, "a_latency", A_S + 1);
        drain(0);

        // Signed then unsigned 0xFF operands, results in consecutive cycles.
        beat(0, '{255, 255, 255, 255, 255}, 1, 0, 0);
        beat(0, '{255, 255, 255, 255, 255}, 0, 0, 0);
        a_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_out_valid) break;
        end
        @(negedge clk);
        check("a_back_to_back", a_out_valid, 1);
        @(posedge clk); #1;
        drain(0);

        // Three-beat accumulation: one pulse, then a plain beat is not polluted.
        o0 = a_outs;
        beat(0, '{1, 1, 1, 1, 1}, 0, 1, 0);
        beat(0, '{1, 1, 1, 1, 1}, 0, 1, 0);
        beat(0, '{1, 1, 1, 1, 1}, 0, 1, 1);
        a_valid = 0;
        drain(0);
        repeat (6) @(negedge clk);
        check("a_acc_pulses", a_outs - o0, 1);
        @(posedge clk); #1;
        beat(0, '{2, 2, 2, 2, 2}, 0, 0, 0);
        a_valid = 0;
        drain(0);

        // Backpressure: 20 continuous beats, output held off for 10 cycles.
        a_out_ready = 0;
        h0 = a_hs;
        fork
            begin
                for (int unsigned n = 0; n < 20; n++) beat(0, '{n, n, n, n, n}, 0, 0, 0);
                a_valid = 0;
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                check("a_bp_buffered", a_hs - h0, A_S + 1);
                @(negedge clk);
                check("a_bp_ready_low", a_ready, 0);
                @(posedge clk); #1;
                a_out_ready = 1;
            end
        join
        drain(0);

        // Instance B: latency 1, signed beat, wrap-around accumulation.
        beat(1, '{3, 4, 0, 0, 0}, 0, 0, 0);
        b_valid = 0;
        latency(1, "b_latency", B_S + 1);
        beat(1, '{8, 15, 0, 0, 0}, 1, 0, 0);
        for (int k = 0; k < 5; k++) beat(1, '{15, 15, 0, 0, 0}, 0, 1, (k == 4));
        b_valid = 0;
        drain(1);

        // Reset with a partial accumulation and four beats held in flight.
        a_out_ready = 0;
        beat(0, '{1, 0, 0, 0, 0}, 0, 1, 0);
        for (int k = 0; k < 4; k++) beat(0, '{3, 3, 3, 3, 3}, 0, 0, 0);
        a_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        check("a_pre_reset_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("a_reset_midflight_valid", a_out_valid, 0);
        a_exp.delete(); a_accm = 0;
        b_exp.delete(); b_accm = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        a_out_ready = 1;
        beat(0, '{1, 1, 1, 2, 2}, 0, 1, 1);
        a_valid = 0;
        drain(0);

        // Randomised mixed traffic on both instances with random backpressure.
        a_rand_rdy = 1;
        b_rand_rdy = 1;
        fork
            begin
                for (int k = 0; k < 120; k++) begin
                    for (int unsigned i = 0; i < 5; i++) ops[i] = $urandom_range(0, 255);
                    beat(0, ops, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        a_valid = 0;
                        @(posedge clk); #1;
                    end
                end
                a_valid = 0;
            end
            begin
                int unsigned bops [5];
                for (int k = 0; k < 100; k++) begin
                    for (int unsigned i = 0; i < 5; i++) bops[i] = $urandom_range(0, 15);
                    beat(1, bops, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        b_valid = 0;
                        @(posedge clk); #1;
                    end
                end
                b_valid = 0;
            end
        join
        drain(0);
        drain(1);
        a_rand_rdy = 0;
        b_rand_rdy = 0;
        @(posedge clk); #1;
        a_out_ready = 1;
        b_out_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        check("a_final_queue_empty", a_exp.size(), 0);
        check("b_final_queue_empty", b_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
